// File: rtl/flash_op_sequencer.sv
// Command sequencer for an SPI flash: turns one user operation (read, page
// program, sector erase, status read) into a sequence of byte transfers on a
// start/done SPI byte engine, owns cs_n, inserts WREN before program/erase and
// polls RDSR until the write-in-progress bit clears.
module flash_op_sequencer #(
  parameter logic [7:0]  CS_GAP_CYC = 8'd4,
  parameter logic [23:0] POLL_MAX   = 24'd600000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        op_req,
  input  logic [1:0]  op_code,
  input  logic [23:0] op_addr,
  input  logic [7:0]  op_len,
  output logic        op_ready,
  output logic        op_done,
  output logic        op_err,
  output logic        wdata_req,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        rdata_valid,
  output logic        spi_start,
  output logic [7:0]  spi_tx,
  input  logic        spi_done,
  input  logic [7:0]  spi_rx,
  output logic        cs_n
);

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_PROG  = 2'd1;
  localparam logic [1:0] OP_ERASE = 2'd2;
  localparam logic [1:0] OP_RDSR  = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_WREN, S_GAP1, S_CMD, S_ADDR, S_DATA, S_GAP2, S_POLL, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  code_q, code_d;
  logic [23:0] addr_q, addr_d;
  logic [8:0]  len_q, len_d;        // 1..256 data bytes
  logic [8:0]  cnt_q, cnt_d;        // addr index / bytes remaining / poll phase
  logic [7:0]  gap_q, gap_d;
  logic [23:0] poll_q, poll_d;
  logic        sent_q, sent_d;      // a byte is in flight on the engine
  logic        wwait_q, wwait_d;    // program byte arrives on wdata this cycle
  logic        cs_n_q, cs_n_d;
  logic        op_ready_q, op_ready_d;
  logic        op_done_q, op_done_d;
  logic        op_err_q, op_err_d;
  logic        wdata_req_q, wdata_req_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        spi_start_q, spi_start_d;
  logic [7:0]  spi_tx_q, spi_tx_d;

  logic [7:0]  opcode;

  // Command opcode for the latched operation
  always_comb begin
    opcode = 8'h03;
    case (code_q)
      OP_READ:  opcode = 8'h03;
      OP_PROG:  opcode = 8'h02;
      OP_ERASE: opcode = 8'hD8;
      OP_RDSR:  opcode = 8'h05;
      default:  opcode = 8'h03;
    endcase
  end

  // Next-state and registered-output logic for the sequencer FSM
  always_comb begin
    state_d       = state_q;
    code_d        = code_q;
    addr_d        = addr_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    gap_d         = gap_q;
    poll_d        = poll_q;
    sent_d        = sent_q;
    wwait_d       = wwait_q;
    cs_n_d        = cs_n_q;
    op_ready_d    = op_ready_q;
    op_done_d     = 1'b0;
    op_err_d      = 1'b0;
    wdata_req_d   = 1'b0;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    spi_start_d   = 1'b0;
    spi_tx_d      = spi_tx_q;

    case (state_q)
      S_IDLE: begin
        if (op_req && op_ready_q) begin
          code_d     = op_code;
          addr_d     = op_addr;
          len_d      = (op_len == 8'd0) ? 9'd256 : {1'b0, op_len};
          poll_d     = 24'd0;
          sent_d     = 1'b0;
          wwait_d    = 1'b0;
          cs_n_d     = 1'b0;
          op_ready_d = 1'b0;
          state_d    = (op_code == OP_PROG || op_code == OP_ERASE) ? S_WREN : S_CMD;
        end
      end
      S_WREN: begin
        if (!sent_q) begin
          spi_start_d = 1'b1;
          spi_tx_d    = 8'h06;
          sent_d      = 1'b1;
        end else if (spi_done) begin
          sent_d  = 1'b0;
          cs_n_d  = 1'b1;
          gap_d   = 8'd0;
          state_d = S_GAP1;
        end
      end
      S_GAP1: begin
        if (gap_q == CS_GAP_CYC - 8'd1) begin
          cs_n_d  = 1'b0;
          state_d = S_CMD;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      S_CMD: begin
        if (!sent_q) begin
          spi_start_d = 1'b1;
          spi_tx_d    = opcode;
          sent_d      = 1'b1;
        end else if (spi_done) begin
          sent_d = 1'b0;
          if (code_q == OP_RDSR) begin
            cnt_d   = 9'd1;
            state_d = S_DATA;
          end else begin
            cnt_d   = 9'd0;
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (!sent_q) begin
          spi_start_d = 1'b1;
          sent_d      = 1'b1;
          case (cnt_q[1:0])
            2'd0:    spi_tx_d = addr_q[23:16];
            2'd1:    spi_tx_d = addr_q[15:8];
            default: spi_tx_d = addr_q[7:0];
          endcase
        end else if (spi_done) begin
          sent_d = 1'b0;
          if (cnt_q == 9'd2) begin
            if (code_q == OP_ERASE) begin
              cs_n_d  = 1'b1;
              gap_d   = 8'd0;
              state_d = S_GAP2;
            end else begin
              cnt_d   = len_q;
              state_d = S_DATA;
            end
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
      end
      S_DATA: begin
        if (!sent_q) begin
          if (code_q == OP_PROG) begin
            // req pulse -> one cycle for the FIFO -> latch wdata and start
            if (wwait_q) begin
              spi_tx_d    = wdata;
              spi_start_d = 1'b1;
              sent_d      = 1'b1;
              wwait_d     = 1'b0;
            end else if (wdata_req_q) begin
              wwait_d = 1'b1;
            end else begin
              wdata_req_d = 1'b1;
            end
          end else begin
            spi_tx_d    = 8'h00;
            spi_start_d = 1'b1;
            sent_d      = 1'b1;
          end
        end else if (spi_done) begin
          sent_d = 1'b0;
          cnt_d  = cnt_q - 9'd1;
          if (code_q != OP_PROG) begin
            rdata_d       = spi_rx;
            rdata_valid_d = 1'b1;
          end
          if (cnt_q == 9'd1) begin
            cs_n_d = 1'b1;
            if (code_q == OP_PROG) begin
              gap_d   = 8'd0;
              state_d = S_GAP2;
            end else begin
              op_done_d = 1'b1;
              state_d   = S_DONE;
            end
          end
        end
      end
      S_GAP2: begin
        if (gap_q == CS_GAP_CYC - 8'd1) begin
          cs_n_d  = 1'b0;
          cnt_d   = 9'd0;
          sent_d  = 1'b0;
          state_d = S_POLL;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      S_POLL: begin
        if (!sent_q) begin
          spi_start_d = 1'b1;
          spi_tx_d    = cnt_q[0] ? 8'h00 : 8'h05;
          sent_d      = 1'b1;
        end else if (spi_done) begin
          sent_d = 1'b0;
          if (!cnt_q[0]) begin
            cnt_d = 9'd1;
          end else begin
            cs_n_d = 1'b1;
            cnt_d  = 9'd0;
            if (!spi_rx[0]) begin
              op_done_d = 1'b1;
              state_d   = S_DONE;
            end else if (poll_q + 24'd1 == POLL_MAX) begin
              op_done_d = 1'b1;
              op_err_d  = 1'b1;
              state_d   = S_DONE;
            end else begin
              poll_d  = poll_q + 24'd1;
              gap_d   = 8'd0;
              state_d = S_GAP2;
            end
          end
        end
      end
      S_DONE: begin
        op_ready_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        cs_n_d     = 1'b1;
        op_ready_d = 1'b1;
        state_d    = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation with cs_n high
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= S_IDLE;
      code_q        <= 2'd0;
      addr_q        <= 24'd0;
      len_q         <= 9'd0;
      cnt_q         <= 9'd0;
      gap_q         <= 8'd0;
      poll_q        <= 24'd0;
      sent_q        <= 1'b0;
      wwait_q       <= 1'b0;
      cs_n_q        <= 1'b1;
      op_ready_q    <= 1'b1;
      op_done_q     <= 1'b0;
      op_err_q      <= 1'b0;
      wdata_req_q   <= 1'b0;
      rdata_q       <= 8'd0;
      rdata_valid_q <= 1'b0;
      spi_start_q   <= 1'b0;
      spi_tx_q      <= 8'd0;
    end else begin
      state_q       <= state_d;
      code_q        <= code_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      gap_q         <= gap_d;
      poll_q        <= poll_d;
      sent_q        <= sent_d;
      wwait_q       <= wwait_d;
      cs_n_q        <= cs_n_d;
      op_ready_q    <= op_ready_d;
      op_done_q     <= op_done_d;
      op_err_q      <= op_err_d;
      wdata_req_q   <= wdata_req_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      spi_start_q   <= spi_start_d;
      spi_tx_q      <= spi_tx_d;
    end
  end

  assign op_ready    = op_ready_q;
  assign op_done     = op_done_q;
  assign op_err      = op_err_q;
  assign wdata_req   = wdata_req_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign spi_start   = spi_start_q;
  assign spi_tx      = spi_tx_q;
  assign cs_n        = cs_n_q;

endmodule
